// File: rtl/rr_arbiter_param.sv
// Round-robin output-port arbiter with packet lock (head flit to tail flit).
// Optional lock-timeout release is enabled with the RR_TIMEOUT_EN macro.
module rr_arbiter_param #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 3,
  parameter int MY_PORT = 2,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] nexthop_addr_i,
  input  logic [NUM_REQ-1:0]        tail_i,
  input  logic                      ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic                      grant_valid_o,
  output logic                      xfer_o,
  output logic                      timeout_o
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam logic [ADDR_W-1:0] MY_CODE   = ADDR_W'(MY_PORT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]    NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [IDX_W-1:0]   idx_d;
  logic [NUM_REQ-1:0] req;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic               release_tail;

  // Input i requests this port when its head flit targets us; the own port
  // never competes, and i never equals MY_PORT when MY_PORT >= NUM_REQ.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = valid_i[i]
               && (nexthop_addr_i[i*ADDR_W +: ADDR_W] == MY_CODE)
               && (i != MY_PORT);
    end
  end

  // Scan ptr, ptr+1, ... wrapping at NUM_REQ rather than at 2**IDX_W.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] slot;
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (a latch).
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    slot      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      slot = IDX_W'(sum);
      if (!win_found && req[slot]) begin
        win_found = 1'b1;
        win_idx   = slot;
      end
    end
  end

  assign grant_valid_o = (state_q == LOCKED);
  assign xfer_o        = grant_valid_o & valid_i[grant_idx_o] & ready_i;
  assign release_tail  = xfer_o & tail_i[grant_idx_o];
  assign next_ptr      = (grant_idx_o == LAST_IDX) ? '0 : grant_idx_o + 1'b1;

`ifdef RR_TIMEOUT_EN
  localparam int               AGE_W     = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT - 1);

  logic [AGE_W-1:0] age_q, age_d;
  logic             timeout_q, timeout_d;

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_o;
    idx_d   = grant_idx_o;
`ifdef RR_TIMEOUT_EN
    age_d     = age_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          grant_d = NUM_REQ'(1) << win_idx;
          idx_d   = win_idx;
`ifdef RR_TIMEOUT_EN
          age_d   = '0;
`endif
        end
      end
      LOCKED: begin
        // Only the tail (or a timeout) releases; request changes are ignored.
        if (release_tail) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          ptr_d   = next_ptr;
        end
`ifdef RR_TIMEOUT_EN
        if (xfer_o) begin
          age_d = '0;
        end else if (age_q == AGE_LIMIT) begin
          state_d   = IDLE;
          grant_d   = '0;
          idx_d     = '0;
          ptr_d     = next_ptr;
          timeout_d = 1'b1;
        end else begin
          age_d = age_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_o     <= '0;
      grant_idx_o <= '0;
`ifdef RR_TIMEOUT_EN
      age_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_o     <= grant_d;
      grant_idx_o <= idx_d;
`ifdef RR_TIMEOUT_EN
      age_q       <= age_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench for rr_arbiter_param (NUM_REQ=5, MY_PORT=2).
// Build with RR_TIMEOUT_EN defined to also exercise the lock timeout (TIMEOUT=8).
module tb_rr_arbiter_param;

  localparam int NUM_REQ = 5;
  localparam int ADDR_W  = 3;
  localparam int MY_PORT = 2;
  localparam int IDX_W   = 3;
  localparam int TIMEOUT = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        valid;
  logic [ADDR_W-1:0]         hop [NUM_REQ];
  logic [NUM_REQ*ADDR_W-1:0] nexthop;
  logic [NUM_REQ-1:0]        tail;
  logic                      ready;
  logic [NUM_REQ-1:0]        grant;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_valid;
  logic                      xfer;
  logic                      timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    nexthop = '0;
    for (int i = 0; i < NUM_REQ; i++) nexthop[i*ADDR_W +: ADDR_W] = hop[i];
  end

  rr_arbiter_param #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .MY_PORT(MY_PORT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid),
    .nexthop_addr_i(nexthop),
    .tail_i        (tail),
    .ready_i       (ready),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid),
    .xfer_o        (xfer),
    .timeout_o     (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic v, input logic [ADDR_W-1:0] h, input logic t);
    valid[i] = v;
    hop[i]   = h;
    tail[i]  = t;
  endtask

  task automatic clear_all();
    valid = '0;
    tail  = '0;
    for (int i = 0; i < NUM_REQ; i++) hop[i] = 3'd7;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    ready = 1'b0;
    clear_all();
    step();
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_idx", 32'(grant_idx), 32'h0);
    check("rst_gv", 32'(grant_valid), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b1;

    // W is this port itself and N targets another port: nothing is granted.
    set_in(2, 1'b1, 3'd2, 1'b1);
    set_in(0, 1'b1, 3'd3, 1'b1);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("uturn_gv", 32'(grant_valid), 32'h0);
    end
    check("uturn_grant", 32'(grant), 32'h0);
    clear_all();

    // N and E single flits: N first, one IDLE cycle, then E.
    set_in(0, 1'b1, 3'd2, 1'b1);
    set_in(3, 1'b1, 3'd2, 1'b1);
    step();
    check("ne_grant_n", 32'(grant), 32'h01);
    check("ne_idx_n", 32'(grant_idx), 32'h0);
    check("ne_gv_n", 32'(grant_valid), 32'h1);
    check("ne_xfer_n", 32'(xfer), 32'h1);
    step();
    check("ne_idle", 32'(grant_valid), 32'h0);
    check("ne_idle_grant", 32'(grant), 32'h0);
    step();
    check("ne_grant_e", 32'(grant), 32'h08);
    check("ne_idx_e", 32'(grant_idx), 32'h3);
    step();
    check("ne_idle2", 32'(grant_valid), 32'h0);
    clear_all();

    // Pointer is now 4: L, N, S, L with single flits.
    set_in(4, 1'b1, 3'd2, 1'b1);
    set_in(0, 1'b1, 3'd2, 1'b1);
    set_in(1, 1'b1, 3'd2, 1'b1);
    step();
    check("wrap_l", 32'(grant), 32'h10);
    step();
    step();
    check("wrap_n", 32'(grant), 32'h01);
    step();
    step();
    check("wrap_s", 32'(grant), 32'h02);
    step();
    step();
    check("wrap_l2", 32'(grant), 32'h10);
    step();
    check("wrap_idle", 32'(grant_valid), 32'h0);
    clear_all();

    // Pointer is 0: 3-flit packet on S, ready 1,0,1,1, L waiting throughout.
    set_in(1, 1'b1, 3'd2, 1'b0);
    set_in(4, 1'b1, 3'd2, 1'b1);
    step();
    check("pkt_grant_s", 32'(grant), 32'h02);
    check("pkt_xfer1", 32'(xfer), 32'h1);
    step();
    ready  = 1'b0;
    hop[1] = 3'd0;
    #1;
    check("pkt_hold_gv", 32'(grant_valid), 32'h1);
    check("pkt_hold_grant", 32'(grant), 32'h02);
    check("pkt_hold_xfer", 32'(xfer), 32'h0);
    step();
    ready  = 1'b1;
    hop[1] = 3'd2;
    #1;
    check("pkt_xfer2", 32'(xfer), 32'h1);
    check("pkt_lock_grant", 32'(grant), 32'h02);
    step();
    tail[1] = 1'b1;
    #1;
    check("pkt_xfer3", 32'(xfer), 32'h1);
    check("pkt_still_s", 32'(grant), 32'h02);
    step();
    check("pkt_release", 32'(grant_valid), 32'h0);
    step();
    check("pkt_grant_l", 32'(grant), 32'h10);
    step();
    check("pkt_l_done", 32'(grant_valid), 32'h0);
    clear_all();

    // Lock on E with ready low, then reset mid-packet without a clock edge.
    set_in(3, 1'b1, 3'd2, 1'b0);
    ready = 1'b0;
    step();
    check("lk_grant_e", 32'(grant), 32'h08);
`ifndef RR_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      step();
      check("lk_persist", 32'(grant_valid), 32'h1);
      check("lk_no_timeout", 32'(timeout), 32'h0);
    end
`endif
    #2;
    reset = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_gv", 32'(grant_valid), 32'h0);
    check("arst_idx", 32'(grant_idx), 32'h0);
    check("arst_xfer", 32'(xfer), 32'h0);
    set_in(0, 1'b1, 3'd2, 1'b1);
    ready = 1'b1;
    #2;
    reset = 1'b1;
    step();
    check("arst_then_n", 32'(grant), 32'h01);
    step();
    clear_all();
    step();

`ifdef RR_TIMEOUT_EN
    // Lock on N with ready low: release after 8 locked cycles, then E from ptr=1.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    set_in(0, 1'b1, 3'd2, 1'b0);
    set_in(3, 1'b1, 3'd2, 1'b1);
    ready = 1'b0;
    step();
    check("to_grant_n", 32'(grant), 32'h01);
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      check("to_locked", 32'(grant_valid), 32'h1);
      check("to_quiet", 32'(timeout), 32'h0);
    end
    step();
    check("to_release", 32'(grant_valid), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    step();
    check("to_pulse_end", 32'(timeout), 32'h0);
    check("to_grant_e", 32'(grant), 32'h08);
    clear_all();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
Parametrised round-robin output-port arbiter for the NOC router; one instance per output port, any direction. Per-input next-hop comparison, rotating-pointer round robin over NUM_REQ inputs with the own port excluded, and a packet-lock FSM that holds a grant from head flit to tail flit. The registered one-hot grant and index drive the crossbar select and input-buffer pop.

Parameters:
NUM_REQ, 5, number of requesting input ports (index 0=N, 1=S, 2=W, 3=E, 4=L)
ADDR_W, 3, width of each next-hop address field
MY_PORT, 2, next-hop code of this output port; also the index of the input excluded from arbitration (no U-turn)
IDX_W, $clog2(NUM_REQ), grant index width
TIMEOUT, 64, lock-timeout cycles; used only with RR_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
valid_i  in  NUM_REQ  per-input head-of-buffer flit valid
nexthop_addr_i  in  NUM_REQ*ADDR_W  packed next-hop codes, input i at [i*ADDR_W +: ADDR_W]
tail_i  in  NUM_REQ  per-input flit is a packet tail (single-flit packet: head = tail)
ready_i  in  1  downstream accepts a flit this cycle
grant_o  out  NUM_REQ  one-hot grant, registered
grant_idx_o  out  IDX_W  binary index of the granted input
grant_valid_o  out  1  a grant is held (LOCKED)
xfer_o  out  1  flit transferred this cycle: grant_valid_o & valid_i[grant_idx_o] & ready_i
timeout_o  out  1  one-cycle pulse on lock timeout; tied 0 without RR_TIMEOUT_EN

Behaviour:
- Request: req[i] = valid_i[i] & (nexthop_addr_i[i] == MY_PORT) & (i != MY_PORT). Combinational.
- Pointer ptr (IDX_W bits), reset to 0. The winner is the first req[i] scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 (modulo NUM_REQ, never the raw IDX_W wrap).
- FSM:
  - IDLE: if any req, register the winner: grant_o, grant_idx_o, grant_valid_o=1, then go to LOCKED. Latency is 1 cycle from request to grant.
  - LOCKED: the grant is held. On xfer_o with tail_i[grant_idx_o]=1, go to IDLE next cycle, clear the grant, and set ptr = (grant_idx_o+1) mod NUM_REQ.
  - LOCKED: on xfer_o without tail, stay LOCKED.
  - LOCKED: with no xfer (ready_i=0 or valid_i low), hold.
- Once locked, req deassertion or nexthop_addr_i changes on the granted input do not release the lock; only the tail releases it.
- After a tail release there is a minimum one IDLE cycle, so back-to-back packets from different inputs are granted two cycles apart.
- Requests arriving during LOCKED wait; the pointer is not updated until release.
- ptr == NUM_REQ-1 wraps to 0. If MY_PORT is the pointer slot, the scan skips it.
- Reset (asynchronous, any state, including mid-packet): state=IDLE, ptr=0, grant_o=0, grant_idx_o=0, grant_valid_o=0, timeout_o=0. Outputs are low on the assertion edge without waiting for clk.
- NUM_REQ must be ≥2. MY_PORT ≥ NUM_REQ means no input is excluded.

Optional Feature:
RR_TIMEOUT_EN
- Defined: a lock-age counter is cleared on entry to LOCKED and on every xfer_o, and increments each LOCKED cycle without xfer.
- Defined, counter reaching TIMEOUT-1: force release to IDLE, pulse timeout_o for 1 cycle, and set ptr = grant_idx_o+1 mod NUM_REQ.
- Undefined: no counter; timeout_o constant 0; locks persist indefinitely.

Test Plan:
- Reset, MY_PORT=2: N(0) and E(3) both valid with nexthop 2, single-flit (tail=1), ready=1 -> cycle 1 grant_o=00001, then IDLE, then grant_o=01000; ptr=4 afterwards.
- Input W(2) valid, nexthop 2 -> never granted; grant_valid_o stays 0.
- 3-flit packet on S(1) with ready toggling 1,0,1,1; L(4) requesting throughout -> grant_o=00010 held until the third xfer with tail, then L granted two cycles later.
- Pointer wrap: ptr=4; L, N, S all request repeatedly with single flits -> grant order L, N, S, L.
- Assert reset mid-packet while locked on E -> grant_o=0 and grant_valid_o=0 immediately. After release, N wins with ptr=0.
- RR_TIMEOUT_EN, TIMEOUT=8: lock on N with ready_i=0 -> timeout_o pulses after 8 locked cycles, grant clears, and next winner is scanned from S.
